// File: rtl/ub_adder_share_arb_if.sv
// rtl/ub_adder_share_arb_if.sv - requester and result bundle for the shared adder arbiter
interface ub_adder_share_arb_if #(
  parameter int NREQ = 4,
  parameter int W    = 29,
  parameter int TAGW = 2
);
  logic [NREQ-1:0]   REQ;
  logic [NREQ-1:0]   GNT;
  logic [NREQ*W-1:0] X_IN;
  logic [NREQ*W-1:0] Y_IN;
  logic [W:0]        S_OUT;
  logic [TAGW-1:0]   S_TAG;
  logic              S_VLD;
  logic              S_RDY;
  logic              BUSY;

  modport master (
    output REQ, X_IN, Y_IN, S_RDY,
    input  GNT, S_OUT, S_TAG, S_VLD, BUSY
  );

  modport slave (
    input  REQ, X_IN, Y_IN, S_RDY,
    output GNT, S_OUT, S_TAG, S_VLD, BUSY
  );
endinterface

// File: rtl/ub_adder_share_arb.sv
// rtl/ub_adder_share_arb.sv - round-robin share of one carry-select adder across requesters
module ub_adder_share_arb #(
  parameter int NREQ = 4,
  parameter int W    = 29,
  parameter int TAGW = 2
) (
  input logic               CLK,
  input logic               RST,
  ub_adder_share_arb_if.slave bus
);
  localparam int LO = W / 2;
  localparam int HI = W - LO;

  logic [TAGW-1:0] ptr;
  logic [TAGW-1:0] gnt_idx;
  logic [TAGW:0]   cand;
  logic            found;
  logic            slot_free;
  logic [NREQ-1:0] gnt;
  logic [W-1:0]    x_sel;
  logic [W-1:0]    y_sel;
  logic [LO:0]     lo_sum;
  logic [HI:0]     hi_sum0;
  logic [HI:0]     hi_sum1;
  logic [W:0]      sum;
  logic [W:0]      s_out_q;
  logic [TAGW-1:0] s_tag_q;
  logic            s_vld_q;

  assign slot_free = !s_vld_q || bus.S_RDY;

  // Search starts at ptr and wraps at NREQ; ptr < NREQ so one subtraction suffices.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (TAGW+1)'(k);
      if (cand >= (TAGW+1)'(NREQ)) cand = cand - (TAGW+1)'(NREQ);
      if (!found && bus.REQ[cand[TAGW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[TAGW-1:0];
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (!RST && slot_free && found) gnt[gnt_idx] = 1'b1;
  end

  always_comb begin
    x_sel = '0;
    y_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (TAGW'(k) == gnt_idx) begin
        x_sel = bus.X_IN[k*W +: W];
        y_sel = bus.Y_IN[k*W +: W];
      end
    end
  end

  // Carry-select: both upper-half candidates are formed in parallel with the lower half.
  always_comb begin
    lo_sum  = {1'b0, x_sel[LO-1:0]} + {1'b0, y_sel[LO-1:0]};
    hi_sum0 = {1'b0, x_sel[W-1:LO]} + {1'b0, y_sel[W-1:LO]};
    hi_sum1 = {1'b0, x_sel[W-1:LO]} + {1'b0, y_sel[W-1:LO]} + (HI+1)'(1);
    sum     = lo_sum[LO] ? {hi_sum1, lo_sum[LO-1:0]} : {hi_sum0, lo_sum[LO-1:0]};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s_vld_q <= 1'b0;
      s_out_q <= '0;
      s_tag_q <= '0;
      ptr     <= '0;
    end else if (|gnt) begin
      s_vld_q <= 1'b1;
      s_out_q <= sum;
      s_tag_q <= gnt_idx;
      ptr     <= (gnt_idx == TAGW'(NREQ-1)) ? '0 : gnt_idx + TAGW'(1);
    end else if (bus.S_RDY) begin
      s_vld_q <= 1'b0;
    end
  end

  assign bus.GNT   = gnt;
  assign bus.S_OUT = s_out_q;
  assign bus.S_TAG = s_tag_q;
  assign bus.S_VLD = s_vld_q;
  assign bus.BUSY  = s_vld_q || (|bus.REQ);
endmodule

// File: tb/tb_ub_adder_share_arb.sv
// tb/tb_ub_adder_share_arb.sv - directed self-checking bench for ub_adder_share_arb
module tb_ub_adder_share_arb;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int total = 0;
  int bad = 0;

  ub_adder_share_arb_if #(.NREQ(4), .W(29), .TAGW(2)) bus ();

  ub_adder_share_arb #(.NREQ(4), .W(29), .TAGW(2)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_op(input int i, input logic [28:0] x, input logic [28:0] y);
    bus.X_IN[i*29 +: 29] = x;
    bus.Y_IN[i*29 +: 29] = y;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus.REQ = 4'b1111;
    bus.S_RDY = 1'b1;
    tick();
    tick();
    total++; if (bus.GNT !== 4'b0000) begin bad++; $display("FAIL rst_gnt got=%b exp=0000", bus.GNT); end
    total++; if (bus.S_VLD !== 1'b0) begin bad++; $display("FAIL rst_vld got=%b exp=0", bus.S_VLD); end
    total++; if (bus.S_OUT !== 30'h0) begin bad++; $display("FAIL rst_out got=%h exp=0", bus.S_OUT); end
    total++; if (bus.S_TAG !== 2'd0) begin bad++; $display("FAIL rst_tag got=%0d exp=0", bus.S_TAG); end
    total++; if (bus.BUSY !== 1'b1) begin bad++; $display("FAIL rst_busy got=%b exp=1", bus.BUSY); end
    RST = 1'b0;
    bus.REQ = 4'b0000;
    tick();
  endtask

  task automatic test_single();
    set_op(0, 29'h1FFFFFFF, 29'h1FFFFFFF);
    bus.REQ = 4'b0001;
    bus.S_RDY = 1'b1;
    #1;
    total++; if (bus.GNT !== 4'b0001) begin bad++; $display("FAIL single_gnt got=%b exp=0001", bus.GNT); end
    tick();
    total++; if (bus.S_VLD !== 1'b1) begin bad++; $display("FAIL single_vld got=%b exp=1", bus.S_VLD); end
    total++; if (bus.S_OUT !== 30'h3FFFFFFE) begin bad++; $display("FAIL single_out got=%h exp=3ffffffe", bus.S_OUT); end
    total++; if (bus.S_TAG !== 2'd0) begin bad++; $display("FAIL single_tag got=%0d exp=0", bus.S_TAG); end
    total++; if (bus.GNT !== 4'b0001) begin bad++; $display("FAIL single_regnt got=%b exp=0001", bus.GNT); end
    tick();
    total++; if (bus.S_VLD !== 1'b1) begin bad++; $display("FAIL single_vld2 got=%b exp=1", bus.S_VLD); end
    bus.REQ = 4'b0000;
    tick();
    total++; if (bus.S_VLD !== 1'b0) begin bad++; $display("FAIL drain_vld got=%b exp=0", bus.S_VLD); end
    total++; if (bus.S_OUT !== 30'h3FFFFFFE) begin bad++; $display("FAIL drain_out got=%h exp=3ffffffe", bus.S_OUT); end
    total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", bus.BUSY); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    for (int i = 0; i < 4; i++) set_op(i, 29'(i), 29'(10 * i));
    bus.REQ = 4'b1111;
    bus.S_RDY = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      exp_gnt = 4'b0001 << (c % 4);
      total++; if (bus.GNT !== exp_gnt) begin bad++; $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, bus.GNT, exp_gnt); end
      tick();
      total++; if (bus.S_VLD !== 1'b1) begin bad++; $display("FAIL rr_vld c=%0d got=%b exp=1", c, bus.S_VLD); end
      total++; if (bus.S_OUT !== 30'(11 * (c % 4))) begin bad++; $display("FAIL rr_out c=%0d got=%0d exp=%0d", c, bus.S_OUT, 11 * (c % 4)); end
      total++; if (bus.S_TAG !== 2'(c % 4)) begin bad++; $display("FAIL rr_tag c=%0d got=%0d exp=%0d", c, bus.S_TAG, c % 4); end
    end
    bus.REQ = 4'b0000;
    tick();
  endtask

  task automatic test_stall_and_wrap();
    bus.REQ = 4'b0110;
    bus.S_RDY = 1'b0;
    #1;
    total++; if (bus.GNT !== 4'b0010) begin bad++; $display("FAIL stall_first_gnt got=%b exp=0010", bus.GNT); end
    tick();
    for (int c = 0; c < 3; c++) begin
      total++; if (bus.GNT !== 4'b0000) begin bad++; $display("FAIL stall_gnt c=%0d got=%b exp=0000", c, bus.GNT); end
      total++; if (bus.S_VLD !== 1'b1) begin bad++; $display("FAIL stall_vld c=%0d got=%b exp=1", c, bus.S_VLD); end
      total++; if (bus.S_TAG !== 2'd1) begin bad++; $display("FAIL stall_tag c=%0d got=%0d exp=1", c, bus.S_TAG); end
      total++; if (bus.S_OUT !== 30'd11) begin bad++; $display("FAIL stall_out c=%0d got=%0d exp=11", c, bus.S_OUT); end
      tick();
    end
    bus.S_RDY = 1'b1;
    #1;
    total++; if (bus.GNT !== 4'b0100) begin bad++; $display("FAIL release_gnt got=%b exp=0100", bus.GNT); end
    tick();
    total++; if (bus.S_TAG !== 2'd2) begin bad++; $display("FAIL release_tag got=%0d exp=2", bus.S_TAG); end
    total++; if (bus.S_OUT !== 30'd22) begin bad++; $display("FAIL release_out got=%0d exp=22", bus.S_OUT); end
    bus.REQ = 4'b0011;
    #1;
    total++; if (bus.GNT !== 4'b0001) begin bad++; $display("FAIL wrap_gnt0 got=%b exp=0001", bus.GNT); end
    tick();
    total++; if (bus.S_TAG !== 2'd0) begin bad++; $display("FAIL wrap_tag0 got=%0d exp=0", bus.S_TAG); end
    total++; if (bus.GNT !== 4'b0010) begin bad++; $display("FAIL wrap_gnt1 got=%b exp=0010", bus.GNT); end
    tick();
    total++; if (bus.S_TAG !== 2'd1) begin bad++; $display("FAIL wrap_tag1 got=%0d exp=1", bus.S_TAG); end
    total++; if (bus.S_OUT !== 30'd11) begin bad++; $display("FAIL wrap_out1 got=%0d exp=11", bus.S_OUT); end
    bus.REQ = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid();
    bus.REQ = 4'b1111;
    bus.S_RDY = 1'b0;
    tick();
    total++; if (bus.S_VLD !== 1'b1 || bus.S_TAG !== 2'd2) begin bad++; $display("FAIL mid_pre got vld=%b tag=%0d exp vld=1 tag=2", bus.S_VLD, bus.S_TAG); end
    RST = 1'b1;
    #1;
    total++; if (bus.GNT !== 4'b0000) begin bad++; $display("FAIL mid_rst_gnt got=%b exp=0000", bus.GNT); end
    tick();
    total++; if (bus.S_VLD !== 1'b0) begin bad++; $display("FAIL mid_rst_vld got=%b exp=0", bus.S_VLD); end
    total++; if (bus.S_OUT !== 30'h0) begin bad++; $display("FAIL mid_rst_out got=%h exp=0", bus.S_OUT); end
    RST = 1'b0;
    bus.S_RDY = 1'b1;
    #1;
    total++; if (bus.GNT !== 4'b0001) begin bad++; $display("FAIL mid_after_gnt got=%b exp=0001", bus.GNT); end
    tick();
    total++; if (bus.S_VLD !== 1'b1 || bus.S_TAG !== 2'd0) begin bad++; $display("FAIL mid_after_res got vld=%b tag=%0d exp vld=1 tag=0", bus.S_VLD, bus.S_TAG); end
    bus.REQ = 4'b0000;
    tick();
  endtask

  task automatic test_withdraw();
    set_op(1, 29'd0, 29'd0);
    set_op(3, 29'd5, 29'd7);
    bus.REQ = 4'b0001;
    bus.S_RDY = 1'b0;
    #1;
    total++; if (bus.GNT !== 4'b0001) begin bad++; $display("FAIL wd_pre_gnt got=%b exp=0001", bus.GNT); end
    tick();
    bus.REQ = 4'b1000;
    #1;
    total++; if (bus.GNT !== 4'b0000) begin bad++; $display("FAIL wd_req3_gnt got=%b exp=0000", bus.GNT); end
    tick();
    bus.REQ = 4'b0000;
    #1;
    total++; if (bus.GNT !== 4'b0000) begin bad++; $display("FAIL wd_drop_gnt got=%b exp=0000", bus.GNT); end
    total++; if (bus.BUSY !== 1'b1) begin bad++; $display("FAIL wd_busy got=%b exp=1", bus.BUSY); end
    tick();
    bus.REQ = 4'b0010;
    bus.S_RDY = 1'b1;
    #1;
    total++; if (bus.GNT !== 4'b0010) begin bad++; $display("FAIL wd_gnt1 got=%b exp=0010", bus.GNT); end
    tick();
    total++; if (bus.S_TAG !== 2'd1) begin bad++; $display("FAIL wd_tag got=%0d exp=1", bus.S_TAG); end
    total++; if (bus.S_OUT !== 30'd0) begin bad++; $display("FAIL wd_out got=%0d exp=0", bus.S_OUT); end
    total++; if (bus.S_VLD !== 1'b1) begin bad++; $display("FAIL wd_vld got=%b exp=1", bus.S_VLD); end
    bus.REQ = 4'b0000;
    tick();
    total++; if (bus.S_VLD !== 1'b0 || bus.S_TAG !== 2'd1) begin bad++; $display("FAIL wd_drain got vld=%b tag=%0d exp vld=0 tag=1", bus.S_VLD, bus.S_TAG); end
    total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL wd_idle_busy got=%b exp=0", bus.BUSY); end
  endtask

  initial begin
    bus.REQ = '0;
    bus.X_IN = '0;
    bus.Y_IN = '0;
    bus.S_RDY = 1'b0;
    tick();
    test_reset();
    test_single();
    test_round_robin();
    test_stall_and_wrap();
    test_reset_mid();
    test_withdraw();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
